odo_meas_ctrl: RTL and testbench
================================

# odo_meas_ctrl

Measurement sequencer for the ring-oscillator aging odometer. It owns the enables of the three reference/stress ROSC pairs (NOR, NAND, INV). It holds the selected stress ring in free-running aging mode while idle. On request it runs a settle-then-count window on one reference/stress pair and latches both edge counts plus their signed difference. It sits between the odometer register interface and the ROSC macros; ring outputs arrive through the external divide-down stage.

## Interface
- `WIN_W`, 16, width of the measurement window length
- `CNT_W`, 16, width of each edge counter
- `SETTLE_CYC`, 8, clock cycles rings run before counting starts (≥1)
- `clk` in 1: single clock; all state on rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `start` in 1: single-cycle measurement request, sampled in IDLE only
- `abort` in 1: cancel measurement, any state
- `sel` in 2: ring type. 0=NOR, 1=NAND, 2=INV, 3=illegal
- `stress_en` in 1: keep stress ring `sel` enabled while IDLE
- `win_len` in WIN_W: counting window in clk cycles, captured at start
- `div_ref` in 3: divided reference ring outputs, asynchronous, index = ring type
- `div_str` in 3: divided stress ring outputs, asynchronous
- `osc_en_ref` out 3: drives reference ROSC `IN` pins
- `osc_en_str` out 3: drives stress ROSC `IN` pins
- `busy` out 1: measurement in progress (SETTLE/MEAS)
- `done` out 1: one-cycle pulse, results updated
- `err` out 1: one-cycle pulse, rejected start
- `cnt_ref` out CNT_W: latched reference edge count
- `cnt_str` out CNT_W: latched stress edge count
- `cnt_diff` out CNT_W+1: signed `cnt_ref - cnt_str`, two's complement
- `sat` out 1: either counter saturated in last measurement

## Operation
- States: IDLE, SETTLE, MEAS, DONE. Reset enters IDLE, and all outputs reset to 0.
- IDLE:
  - `osc_en_ref`=0.
  - `osc_en_str` is one-hot at `sel` when `stress_en`=1 and `sel`≠3, otherwise 0. This output follows `sel`/`stress_en` combinationally through a register, so it has 1-cycle latency.
- `start`=1 in IDLE:
  - If `sel`=3 or `win_len`=0: `err` pulses next cycle and the state stays IDLE.
  - Otherwise: capture `sel` and `win_len`, clear the working counters, and go to SETTLE.
  - `start` in any other state is ignored.
- SETTLE:
  - `osc_en_ref` and `osc_en_str` are both one-hot at the captured `sel`. Other bits are 0, so stress on other rings pauses.
  - Lasts exactly SETTLE_CYC cycles, then goes to MEAS.
- Edge detection:
  - Each `div_*` bit passes through a 2-flop synchronizer, plus a third flop used for rising-edge detection.
  - Only the captured-index bit is counted.
  - Inputs must toggle slower than clk/4; faster inputs give undefined counts.
- MEAS:
  - Lasts exactly `win_len` cycles.
  - Each detected rising edge increments the corresponding working counter.
  - Counters saturate at 2^CNT_W−1, which sets the working sat flag.
  - Edges detected outside MEAS are not counted.
- DONE, one cycle:
  - `cnt_ref`, `cnt_str`, `cnt_diff`, `sat` load from the working values and hold until the next DONE.
  - `done`=1.
  - Enables revert to IDLE rules on the next cycle.
  - Then go to IDLE.
- `abort`=1 in SETTLE/MEAS/DONE:
  - Go to IDLE next cycle with no `done`, and outputs are not updated.
  - If abort is asserted in the DONE cycle, `done` still pulses that cycle, because results already loaded.
- `abort` and `start` in the same IDLE cycle: abort wins, and no `err` is raised.
- `cnt_diff` is computed with both operands zero-extended to CNT_W+1 bits and is registered in DONE.

## Timing
- Cycle 0: `start` sampled.
- Cycles 1..SETTLE_CYC: SETTLE, `busy`=1, enables asserted.
- Cycles SETTLE_CYC+1 .. SETTLE_CYC+`win_len`: MEAS, `busy`=1.
- Cycle SETTLE_CYC+`win_len`+1: DONE, `busy`=0, `done`=1, results valid.
- Earliest next accepted `start`: cycle SETTLE_CYC+`win_len`+2.
- Edge latency from a `div_*` transition to a counter increment is 3–4 cycles. An edge arriving in the last 3 MEAS cycles may be missed; this is accepted.
- `err` appears 1 cycle after the rejected `start`.
- `rst_n` low mid-measurement: all outputs clear immediately (asynchronously), including latched results.

## Test plan
- Reset, with `stress_en`=1 and `sel`=2 held → all outputs 0 during reset; `osc_en_str`=3'b100 one cycle after release; `osc_en_ref`=0.
- `sel`=0, `win_len`=100, `div_ref` period 8 clk, `div_str` period 10 clk → `done` at cycle 109; `cnt_ref`=12±1, `cnt_str`=10±1; `cnt_diff`=`cnt_ref`−`cnt_str`; `sat`=0; `busy` high for cycles 1–108.
- CNT_W=4, `win_len`=200, `div_ref` period 8 → `cnt_ref`=15, `sat`=1; `div_str` idle → `cnt_str`=0, `cnt_diff`=+15.
- `start` with `sel`=3, then with `win_len`=0 → `err` pulse each time, `busy` stays 0, and results are unchanged from the previous run.
- `abort` at MEAS cycle 20 → IDLE next cycle, no `done`, previous results retained; a fresh `start` is then accepted.
- `start` pulsed during MEAS, and `start`+`abort` together in IDLE → both ignored: no restart, no `err`, no state change.

Source files
------------

// File: rtl/odo_meas_ctrl.sv
// Measurement sequencer for the ring-oscillator aging odometer.
//
// Keeps the selected stress ring free-running while idle. On request it runs a
// settle-then-count window on one reference/stress pair and latches both edge
// counts plus their signed difference.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          single-cycle request / cancel
//   sel                   ring type (0 NOR, 1 NAND, 2 INV, 3 illegal)
//   stress_en             keep stress ring 'sel' running while idle
//   win_len               counting window in clk cycles, captured at start
//   div_ref, div_str      divided ring outputs (asynchronous)
//   osc_en_ref/str        ROSC enables
//   busy, done, err       status (done/err are one-cycle pulses)
//   cnt_ref, cnt_str      latched edge counts
//   cnt_diff              signed cnt_ref - cnt_str, one bit wider
//   sat                   a counter saturated in the last measurement
module odo_meas_ctrl #(
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       sel,
    input  logic             stress_en,
    input  logic [WIN_W-1:0] win_len,
    input  logic [2:0]       div_ref,
    input  logic [2:0]       div_str,
    output logic [2:0]       osc_en_ref,
    output logic [2:0]       osc_en_str,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cnt_ref,
    output logic [CNT_W-1:0] cnt_str,
    output logic [CNT_W:0]   cnt_diff,
    output logic             sat
);

    localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StMeas, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [SetW-1:0]  set_cnt_q, set_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] wk_ref_q, wk_ref_d, wk_str_q, wk_str_d;
    logic             wk_sat_q, wk_sat_d;
    logic             load;

    // 2-flop synchronizer plus one extra stage for rising-edge detection
    logic [2:0] ref_s1_q, ref_s2_q, ref_s3_q;
    logic [2:0] str_s1_q, str_s2_q, str_s3_q;
    logic       rise_ref, rise_str;

    logic [2:0] osc_en_ref_d, osc_en_str_d;
    logic       busy_d, done_d, err_d;

    // Shift yields 0 for sel_q == 3, which cannot be captured anyway
    assign rise_ref = |((ref_s2_q & ~ref_s3_q) & (3'b001 << sel_q));
    assign rise_str = |((str_s2_q & ~str_s3_q) & (3'b001 << sel_q));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        set_cnt_d = set_cnt_q;
        win_cnt_d = win_cnt_q;
        wk_ref_d  = wk_ref_q;
        wk_str_d  = wk_str_q;
        wk_sat_d  = wk_sat_q;
        load      = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if (sel == 2'd3 || win_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d     = sel;
                        win_cnt_d = win_len - 1'b1;
                        set_cnt_d = SetW'(SETTLE_CYC - 1);
                        wk_ref_d  = '0;
                        wk_str_d  = '0;
                        wk_sat_d  = 1'b0;
                        state_d   = StSettle;
                    end
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (set_cnt_q == '0) begin
                    state_d = StMeas;
                end else begin
                    set_cnt_d = set_cnt_q - 1'b1;
                end
            end
            StMeas: begin
                if (rise_ref) begin
                    if (wk_ref_q != '1) wk_ref_d = wk_ref_q + 1'b1;
                    else                wk_sat_d = 1'b1;
                end
                if (rise_str) begin
                    if (wk_str_q != '1) wk_str_d = wk_str_q + 1'b1;
                    else                wk_sat_d = 1'b1;
                end
                if (abort) begin
                    state_d = StIdle;
                end else if (win_cnt_q == '0) begin
                    // Results load on entry so they are valid during DONE
                    state_d = StDone;
                    load    = 1'b1;
                end else begin
                    win_cnt_d = win_cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StIdle) begin
            osc_en_ref_d = 3'b000;
            osc_en_str_d = (stress_en && sel != 2'd3) ? (3'b001 << sel) : 3'b000;
        end else begin
            osc_en_ref_d = 3'b001 << sel_d;
            osc_en_str_d = 3'b001 << sel_d;
        end

        busy_d = (state_d == StSettle) || (state_d == StMeas);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            set_cnt_q  <= '0;
            win_cnt_q  <= '0;
            wk_ref_q   <= '0;
            wk_str_q   <= '0;
            wk_sat_q   <= 1'b0;
            ref_s1_q   <= '0;
            ref_s2_q   <= '0;
            ref_s3_q   <= '0;
            str_s1_q   <= '0;
            str_s2_q   <= '0;
            str_s3_q   <= '0;
            osc_en_ref <= '0;
            osc_en_str <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cnt_ref    <= '0;
            cnt_str    <= '0;
            cnt_diff   <= '0;
            sat        <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            set_cnt_q  <= set_cnt_d;
            win_cnt_q  <= win_cnt_d;
            wk_ref_q   <= wk_ref_d;
            wk_str_q   <= wk_str_d;
            wk_sat_q   <= wk_sat_d;
            ref_s1_q   <= div_ref;
            ref_s2_q   <= ref_s1_q;
            ref_s3_q   <= ref_s2_q;
            str_s1_q   <= div_str;
            str_s2_q   <= str_s1_q;
            str_s3_q   <= str_s2_q;
            osc_en_ref <= osc_en_ref_d;
            osc_en_str <= osc_en_str_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            if (load) begin
                cnt_ref  <= wk_ref_d;
                cnt_str  <= wk_str_d;
                cnt_diff <= {1'b0, wk_ref_d} - {1'b0, wk_str_d};
                sat      <= wk_sat_d;
            end
        end
    end

endmodule

// File: tb/tb_odo_meas_ctrl.sv
module tb_odo_meas_ctrl;

    localparam int unsigned WIN_W      = 16;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SETTLE_CYC = 8;
    localparam int          S          = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       sel = 2'd2;
    logic             stress_en = 1'b1;
    logic [WIN_W-1:0] win_len = '0;
    logic [2:0]       div_ref = 3'b000;
    logic [2:0]       div_str = 3'b000;
    logic [2:0]       osc_en_ref, osc_en_str;
    logic             busy, done, err, sat;
    logic [CNT_W-1:0] cnt_ref, cnt_str;
    logic [CNT_W:0]   cnt_diff;

    odo_meas_ctrl #(
        .WIN_W      (WIN_W),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .sel        (sel),
        .stress_en  (stress_en),
        .win_len    (win_len),
        .div_ref    (div_ref),
        .div_str    (div_str),
        .osc_en_ref (osc_en_ref),
        .osc_en_str (osc_en_str),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cnt_ref    (cnt_ref),
        .cnt_str    (cnt_str),
        .cnt_diff   (cnt_diff),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cref;
        int cstr;
        int cdiff;
        int csat;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    exp_t e_pop;
    int   err_pop;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT pulses done/err
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e_pop = exp_q.pop_front();
                check("done_cycle", cyc, e_pop.cyc);
                check("cnt_ref", cnt_ref, e_pop.cref);
                check("cnt_str", cnt_str, e_pop.cstr);
                check("cnt_diff", cnt_diff, e_pop.cdiff);
                check("sat", sat, e_pop.csat);
            end
        end
        if (err === 1'b1) begin
            if (err_q.size() == 0) begin
                check("unexpected_err", 32'd1, 32'd0);
            end else begin
                err_pop = err_q.pop_front();
                check("err_cycle", cyc, err_pop);
            end
        end
    end

    // One measurement; c counts cycles from the start cycle (c = 0).
    // Rings rise where (c % period) first reaches period/2; period 0 = idle.
    task automatic run(input logic [1:0] s, input int win, input int rper, input int sper,
                       input int abort_c, input int start_c,
                       input int er, input int es, input int ed, input int esat);
        exp_t e;
        for (int c = 0; c < S + win + 4; c++) begin
            @(negedge clk);
            start   = (c == 0) || (c == start_c);
            abort   = (c == abort_c);
            sel     = s;
            win_len = WIN_W'(win);
            div_ref = (rper != 0 && (c % rper) >= rper / 2) ? (3'b001 << s) : 3'b000;
            div_str = (sper != 0 && (c % sper) >= sper / 2) ? (3'b001 << s) : 3'b000;
            if (c == 0) begin
                check("busy_at_start", busy, 0);
                if (abort_c < 0) begin
                    e.cyc   = cyc + S + win + 1;
                    e.cref  = er;
                    e.cstr  = es;
                    e.cdiff = ed;
                    e.csat  = esat;
                    exp_q.push_back(e);
                end
            end
            if (c == 1) begin
                check("busy_first", busy, 1);
                check("osc_en_ref_settle", osc_en_ref, 32'd1 << s);
                check("osc_en_str_settle", osc_en_str, 32'd1 << s);
            end
            if (abort_c < 0) begin
                if (c == S + win)     check("busy_last", busy, 1);
                if (c == S + win + 1) check("busy_done", busy, 0);
            end else if (c == abort_c + 1) begin
                check("busy_after_abort", busy, 0);
            end
        end
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        div_ref = 3'b000;
        div_str = 3'b000;
    endtask

    task automatic check_results(input int er, input int es, input int ed, input int esat);
        check("hold_cnt_ref", cnt_ref, er);
        check("hold_cnt_str", cnt_str, es);
        check("hold_cnt_diff", cnt_diff, ed);
        check("hold_sat", sat, esat);
    endtask

    initial begin
        // Reset with stress on INV
        repeat (2) @(negedge clk);
        check("rst_osc_en_ref", osc_en_ref, 0);
        check("rst_osc_en_str", osc_en_str, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check_results(0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_osc_en_str", osc_en_str, 3'b100);
        check("idle_osc_en_ref", osc_en_ref, 0);

        // NOR, ref period 8 -> 12 edges, str period 10 -> 10 edges
        run(2'd0, 100, 8, 10, -1, -1, 12, 10, 2, 0);
        // NAND, ref saturates at 15, str idle
        run(2'd1, 200, 8, 0, -1, -1, 15, 0, 15, 1);
        // INV, ref idle, str 5 edges -> diff -5 in 5 bits
        run(2'd2, 40, 0, 8, -1, -1, 0, 5, 27, 0);

        // Rejected starts: illegal sel, then zero window
        @(negedge clk);
        sel = 2'd3; win_len = 16'd10; start = 1'b1;
        err_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        check("busy_bad_sel", busy, 0);
        @(negedge clk);
        sel = 2'd0; win_len = 16'd0; start = 1'b1;
        err_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        check("busy_zero_win", busy, 0);
        repeat (2) @(negedge clk);
        check_results(0, 5, 27, 0);

        // Abort at the 20th MEAS cycle, results retained
        run(2'd0, 100, 8, 10, S + 20, -1, 0, 0, 0, 0);
        check_results(0, 5, 27, 0);

        // Fresh start accepted; a start during MEAS is ignored
        run(2'd0, 100, 8, 10, -1, 30, 12, 10, 2, 0);

        // start + abort together in IDLE: ignored, no err
        @(negedge clk);
        sel = 2'd3; win_len = 16'd10; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("busy_start_abort_bad", busy, 0);
        sel = 2'd0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("busy_start_abort_ok", busy, 0);
        repeat (3) @(negedge clk);
        check("busy_still_idle", busy, 0);

        // Asynchronous reset mid-measurement clears everything at once
        sel = 2'd0; win_len = 16'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", busy, 0);
        check("areset_osc_en_ref", osc_en_ref, 0);
        check("areset_osc_en_str", osc_en_str, 0);
        check_results(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4) @(negedge clk);
        check("pending_done", exp_q.size(), 0);
        check("pending_err", err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
